// File: rtl/traffic_sensor_cond_pkg.sv
// traffic_sensor_pkg: shared debounce state enum, default parameters and a counter-width helper
package traffic_sensor_pkg;
  typedef enum logic [1:0] {LOW, CONF_HIGH, HIGH, CONF_LOW} deb_state_t;
  localparam int DEF_DEB_CYC   = 4;
  localparam int DEF_HOLD_CYC  = 8;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_STUCK_CYC = 1024;
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/traffic_sensor_cond_if.sv
// traffic_sensor_cond_if: raw loop detector inputs and conditioned traffic outputs; master drives detectors, slave is the conditioner
interface traffic_sensor_cond_if
  import traffic_sensor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             det_a_arr, det_a_dep, det_b_arr, det_b_dep;
  logic             ta, tb, ovf_a, ovf_b, fault_a, fault_b;
  logic [CNT_W-1:0] qcnt_a, qcnt_b;
  modport master (
    output det_a_arr, det_a_dep, det_b_arr, det_b_dep,
    input  ta, tb, qcnt_a, qcnt_b, ovf_a, ovf_b, fault_a, fault_b
  );
  modport slave (
    input  det_a_arr, det_a_dep, det_b_arr, det_b_dep,
    output ta, tb, qcnt_a, qcnt_b, ovf_a, ovf_b, fault_a, fault_b
  );
endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser, LOW/CONF_HIGH/HIGH/CONF_LOW debounce FSM (ports clk, rst_n, raw -> lvl, rise)
module sensor_debounce
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise
);
  localparam int W = cnt_w(DEB_CYC);
  logic [1:0]   sync;
  logic [W-1:0] cnt;
  deb_state_t   st;
  logic         s;
  assign s   = sync[1];
  assign lvl = (st == HIGH) || (st == CONF_LOW);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      st   <= LOW;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      case (st)
        LOW: if (s) begin
          cnt  <= W'(1);
          st   <= (DEB_CYC <= 1) ? HIGH : CONF_HIGH;
          rise <= (DEB_CYC <= 1);
        end
        CONF_HIGH: if (!s) st <= LOW;
          else if (cnt == W'(DEB_CYC - 1)) begin
            st   <= HIGH;
            rise <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HIGH: if (!s) begin
          cnt <= W'(1);
          st  <= (DEB_CYC <= 1) ? LOW : CONF_LOW;
        end
        CONF_LOW: if (s) st <= HIGH;
          else if (cnt == W'(DEB_CYC - 1)) st <= LOW;
          else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: per-road debounce, queue count, gap hold -> ta/tb (clk, rst_n, bus: detectors in, ta/tb/qcnt/ovf/fault out); optional SENSOR_STUCK_DET_EN
module traffic_sensor_cond
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_CYC   = DEF_DEB_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STUCK_CYC = DEF_STUCK_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_sensor_cond_if.slave bus
);
  localparam int HW = cnt_w(HOLD_CYC);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [1:0]       raw_arr, raw_dep, rise_arr, rise_dep, lvl_arr, unused_lvl;
  logic [1:0]       ta_v, ovf_v, fault_v;
  logic [CNT_W-1:0] q_v [2];
  assign raw_arr = {bus.det_b_arr, bus.det_a_arr};
  assign raw_dep = {bus.det_b_dep, bus.det_a_dep};
  for (genvar r = 0; r < 2; r++) begin : g_road
    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_arr (
      .clk(clk), .rst_n(rst_n), .raw(raw_arr[r]), .lvl(lvl_arr[r]), .rise(rise_arr[r])
    );
    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_dep (
      .clk(clk), .rst_n(rst_n), .raw(raw_dep[r]), .lvl(unused_lvl[r]), .rise(rise_dep[r])
    );
    logic [CNT_W-1:0] q, qn;
    logic [HW-1:0]    h, hn;
    logic             ad, dd, t, o, fn;
    assign ad = rise_arr[r] & ~rise_dep[r];
    assign dd = rise_dep[r] & ~rise_arr[r];
    always_comb begin
      qn = ad ? (q == MAX ? q : q + 1'b1) : dd ? (q == '0 ? q : q - 1'b1) : q;
      // hold reloads only on the 1->0 step of the queue, then counts down
      hn = (qn != '0) ? '0 : (q != '0) ? HW'(HOLD_CYC) : (h != '0) ? h - 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
        h <= '0;
        o <= 1'b0;
        t <= 1'b0;
      end else begin
        q <= qn;
        h <= hn;
        o <= o | (ad && q == MAX);
        t <= fn || qn != '0 || hn != '0;
      end
    end
`ifdef SENSOR_STUCK_DET_EN
    localparam int SW = cnt_w(STUCK_CYC);
    logic [SW-1:0] s;
    logic          f;
    // fault is raised on the cycle the high time reaches STUCK_CYC and then forces t high
    assign fn = f | (lvl_arr[r] && s == SW'(STUCK_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s <= '0;
        f <= 1'b0;
      end else begin
        s <= !lvl_arr[r] ? '0 : (s == SW'(STUCK_CYC - 1)) ? s : s + 1'b1;
        f <= fn;
      end
    end
    assign fault_v[r] = f;
`else
    logic unused_stuck;
    assign unused_stuck = lvl_arr[r] ^ (^STUCK_CYC);
    assign fn           = 1'b0;
    assign fault_v[r]   = 1'b0;
`endif
    assign q_v[r]   = q;
    assign ta_v[r]  = t;
    assign ovf_v[r] = o;
  end
  assign bus.ta      = ta_v[0];
  assign bus.tb      = ta_v[1];
  assign bus.qcnt_a  = q_v[0];
  assign bus.qcnt_b  = q_v[1];
  assign bus.ovf_a   = ovf_v[0];
  assign bus.ovf_b   = ovf_v[1];
  assign bus.fault_a = fault_v[0];
  assign bus.fault_b = fault_v[1];
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond: table-driven and sequence checks of traffic_sensor_cond (default build)
module tb_traffic_sensor_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  traffic_sensor_cond_if #(.CNT_W(4)) bus ();
  traffic_sensor_cond #(.DEB_CYC(4), .HOLD_CYC(8), .CNT_W(4), .STUCK_CYC(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    logic [3:0] det;
    int         hi;
    logic [3:0] qa, qb;
    logic       ta, tb, oa, ob;
  } vec_t;
  vec_t tbl [15];
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(logic [3:0] d);
    {bus.det_a_arr, bus.det_a_dep, bus.det_b_arr, bus.det_b_dep} = d;
  endtask
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] outs();
    return {2'b00, bus.qcnt_a, bus.qcnt_b, bus.ta, bus.tb, bus.ovf_a, bus.ovf_b, bus.fault_a, bus.fault_b};
  endfunction
  task automatic apply(logic [3:0] d, int hi);
    drive(d);
    step(hi);
    drive(4'b0000);
    step(16 - hi);
  endtask
  initial begin
    tbl[0]  = '{4'b0000, 0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b1000, 6, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 6, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0010, 6, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b0100, 6, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b1010, 6, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{4'b0010, 6, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'b0011, 6, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0100, 6, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'b0100, 6, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'b0100, 6, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{4'b0001, 6, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{4'b0101, 6, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'b0001, 6, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(4'b0000);
    step(2);
    chk("reset_state", outs(), 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].det, tbl[i].hi);
      chk($sformatf("vec%0d", i), outs(),
          {2'b00, tbl[i].qa, tbl[i].qb, tbl[i].ta, tbl[i].tb, tbl[i].oa, tbl[i].ob, 2'b00});
    end
    // latency: raw rise -> qcnt_a/ta after the 7th edge
    drive(4'b1000);
    step(6);
    chk("lat_e6_qa", {12'd0, bus.qcnt_a}, 16'd0);
    chk("lat_e6_ta", {15'd0, bus.ta}, 16'd0);
    step(1);
    chk("lat_e7_qa", {12'd0, bus.qcnt_a}, 16'd1);
    chk("lat_e7_tatb", {14'd0, bus.ta, bus.tb}, 16'd2);
    step(13);
    drive(4'b0000);
    step(12);
    chk("long_press_qa", {12'd0, bus.qcnt_a}, 16'd1);
    // hold window: departure empties queue at edge 7, ta falls at edge 15
    drive(4'b0100);
    step(6);
    drive(4'b0000);
    for (int k = 7; k <= 16; k++) begin
      step(1);
      chk($sformatf("hold_ta_e%0d", k), {15'd0, bus.ta}, {15'd0, k < 15});
    end
    chk("hold_qa", {12'd0, bus.qcnt_a}, 16'd0);
    step(6);
    // hold interrupted by a new arrival
    apply(4'b1000, 6);
    drive(4'b0100);
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 5) drive(4'b1100);
      if (c == 11) drive(4'b0000);
      chk($sformatf("hold_int_ta_c%0d", c), {15'd0, bus.ta}, 16'd1);
    end
    step(10);
    chk("hold_int_qa", {12'd0, bus.qcnt_a}, 16'd1);
    // saturation from a clean reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) apply(4'b1000, 6);
    chk("sat15", {11'd0, bus.qcnt_a, bus.ovf_a}, {11'd0, 4'd15, 1'b0});
    apply(4'b1000, 6);
    chk("sat16", {11'd0, bus.qcnt_a, bus.ovf_a}, {11'd0, 4'd15, 1'b1});
    chk("sat_other_road", {12'd0, bus.qcnt_b}, 16'd0);
    // asynchronous reset mid-debounce, between clock edges
    drive(4'b1010);
    step(3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", outs(), 16'h0000);
    drive(4'b0000);
    step(2);
    chk("rst_held", outs(), 16'h0000);
    rst_n = 1'b1;
    step(20);
    chk("after_rst", outs(), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
